// File: rtl/mdu_delay_fsm.sv
// Cycle-occupancy model of the multiply/divide unit: Busy for the fixed op
// latency, then a one-cycle dataReady pulse. No arithmetic is performed here.
//
//   state | meaning
//   IDLE  | cnt == 0, ready == 0; a valid Mode starts an operation
//   RUN   | cnt != 0; counting down, Mode ignored
//   DONE  | cnt == 0, ready == 1 for one cycle; a new start is accepted here
module mdu_delay_fsm #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] MDU_DelayFSM_i_Mode,
  output logic       MDU_DelayFSM_o_Busy,
  output logic       MDU_DelayFSM_o_dataReady
);

  typedef enum logic [2:0] {
    KIND_NONE = 3'd0,
    KIND_MUL  = 3'd1,
    KIND_DIV  = 3'd2
  } kind_e;

  localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES);

  logic [3:0] cnt_q, cnt_d;
  kind_e      kind_q, kind_d;
  logic       ready_q, ready_d;
  logic       busy_q, busy_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q   <= 4'd0;
      kind_q  <= KIND_NONE;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      kind_q  <= kind_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    cnt_d   = cnt_q;
    kind_d  = kind_q;
    ready_d = 1'b0;
    if (cnt_q != 4'd0) begin
      cnt_d   = cnt_q - 4'd1;
      ready_d = (cnt_q == 4'd1);
    end else begin
      // Signed and unsigned variants share latency; codes 5..15 mean no request.
      unique case (MDU_DelayFSM_i_Mode)
        4'd1, 4'd2: begin
          cnt_d  = MULT_LOAD;
          kind_d = KIND_MUL;
        end
        4'd3, 4'd4: begin
          cnt_d  = DIV_LOAD;
          kind_d = KIND_DIV;
        end
        default: ;
      endcase
    end
    busy_d = (cnt_d != 4'd0);
  end

  assign MDU_DelayFSM_o_Busy      = busy_q;
  assign MDU_DelayFSM_o_dataReady = ready_q;

  // An active countdown must always have been started by a known op kind.
  a_kind_valid : assert property (@(posedge clk) disable iff (reset)
    (cnt_q != 4'd0) |-> (kind_q != KIND_NONE));

endmodule

// File: tb/tb_mdu_delay_fsm.sv
// Directed bench for mdu_delay_fsm: expected {Busy,dataReady} per cycle is
// queued as each input is driven and checked after the following edge.
module tb_mdu_delay_fsm;

  logic       clk;
  logic       reset;
  logic [3:0] mode;
  logic       busy;
  logic       data_ready;

  int tests_run = 0;
  int tests_failed = 0;
  string tag;
  logic [1:0] exp_q[$];

  mdu_delay_fsm #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk                      (clk),
    .reset                    (reset),
    .MDU_DelayFSM_i_Mode      (mode),
    .MDU_DelayFSM_o_Busy      (busy),
    .MDU_DelayFSM_o_dataReady (data_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs, queue the expected outputs after the edge,
  // then pop and compare on the falling edge.
  task automatic cyc(input logic [3:0] m, input logic rst, input logic eb, input logic er);
    logic [1:0] exp_v;
    logic [1:0] obs_v;
    mode  = m;
    reset = rst;
    exp_q.push_back({eb, er});
    @(posedge clk);
    @(negedge clk);
    obs_v = {busy, data_ready};
    tests_run++;
    if (exp_q.size() == 0) begin
      tests_failed++;
      $error("FAIL %s scoreboard empty, busy/ready=%b", tag, obs_v);
    end else begin
      exp_v = exp_q.pop_front();
      assert (obs_v === exp_v) else begin
        tests_failed++;
        $error("FAIL %s busy/ready observed=%b expected=%b", tag, obs_v, exp_v);
      end
    end
  endtask

  // One operation pulse followed by idle: N busy cycles, one ready, one idle.
  task automatic op(input logic [3:0] m, input int n);
    cyc(m, 1'b0, 1'b1, 1'b0);
    for (int i = 1; i < n; i++) cyc(4'd0, 1'b0, 1'b1, 1'b0);
    cyc(4'd0, 1'b0, 1'b0, 1'b1);
    cyc(4'd0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    reset = 1'b1;
    mode  = 4'd0;

    tag = "reset";
    cyc(4'd0, 1'b1, 1'b0, 1'b0);
    cyc(4'd1, 1'b1, 1'b0, 1'b0);

    tag = "idle_mode0";
    for (int i = 0; i < 10; i++) cyc(4'd0, 1'b0, 1'b0, 1'b0);

    tag = "mult";   op(4'd1, 5);
    tag = "multu";  op(4'd2, 5);
    tag = "div";    op(4'd3, 10);
    tag = "divu";   op(4'd4, 10);

    // DIV request on the third busy cycle of a MULT must be ignored.
    tag = "ignore_during_run";
    cyc(4'd1, 1'b0, 1'b1, 1'b0);
    cyc(4'd0, 1'b0, 1'b1, 1'b0);
    cyc(4'd0, 1'b0, 1'b1, 1'b0);
    cyc(4'd3, 1'b0, 1'b1, 1'b0);
    cyc(4'd0, 1'b0, 1'b1, 1'b0);
    cyc(4'd0, 1'b0, 1'b0, 1'b1);
    cyc(4'd0, 1'b0, 1'b0, 1'b0);

    tag = "reset_abort";
    cyc(4'd4, 1'b0, 1'b1, 1'b0);
    cyc(4'd0, 1'b0, 1'b1, 1'b0);
    cyc(4'd0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 12; i++) cyc(4'd0, 1'b0, 1'b0, 1'b0);

    tag = "held_mult";
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 5; i++) cyc(4'd1, 1'b0, 1'b1, 1'b0);
      cyc(4'd1, 1'b0, 1'b0, 1'b1);
    end
    cyc(4'd0, 1'b0, 1'b0, 1'b0);

    // Start accepted in the DONE cycle: DIV begins right after a MULT's ready.
    tag = "done_to_div";
    for (int i = 0; i < 5; i++) cyc(i == 0 ? 4'd2 : 4'd0, 1'b0, 1'b1, 1'b0);
    cyc(4'd0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) cyc(i == 0 ? 4'd3 : 4'd0, 1'b0, 1'b1, 1'b0);
    cyc(4'd0, 1'b0, 1'b0, 1'b1);
    cyc(4'd0, 1'b0, 1'b0, 1'b0);

    tag = "illegal_modes";
    for (int i = 0; i < 4; i++) cyc(4'd7, 1'b0, 1'b0, 1'b0);
    cyc(4'd5, 1'b0, 1'b0, 1'b0);
    cyc(4'd15, 1'b0, 1'b0, 1'b0);
    cyc(4'd0, 1'b0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
